seg_display_capture: RTL



---
 rtl/seg_display_capture_if.sv | 24 ++
 rtl/seg_display_capture.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/seg_display_capture_if.sv
// Bus bundle for the seven-segment capture block: scanned display lines in,
// rebuilt characters and status strobes out.
interface seg_display_capture_if;
    logic [7:0] segments;
    logic [3:0] digit_select;
    logic [7:0] char0;
    logic [7:0] char1;
    logic [7:0] char2;
    logic [7:0] char3;
    logic [3:0] char_valid;
    logic       frame_done;
    logic       changed;
    logic       timeout;

    modport slave (
        input  segments, digit_select,
        output char0, char1, char2, char3, char_valid, frame_done, changed, timeout
    );

    modport master (
        output segments, digit_select,
        input  char0, char1, char2, char3, char_valid, frame_done, changed, timeout
    );
endinterface

// File: rtl/seg_display_capture.sv
// Rebuilds four ASCII chars from a scanned 7-seg bus; a pair commits STABLE_CNT
// edges after it is registered. Pure observer: no backpressure to the display side.
module seg_display_capture #(
    parameter int unsigned STABLE_CNT = 1,
    parameter int unsigned TIMEOUT    = 1024
) (
    input logic                  clk,
    input logic                  rst,
    seg_display_capture_if.slave bus
);
    localparam int unsigned    TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  T_LIM   = TW'(TIMEOUT);
    localparam logic [7:0]     RUN_LIM = 8'(STABLE_CNT);

    typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;

    state_t            state_q, state_d;
    logic [7:0]        seg_q;
    logic [3:0]        sel_q;
    logic [11:0]       prev_q;
    logic [7:0]        run_q, run_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [3:0][7:0]   char_q, char_d;
    logic [3:0]        valid_q, valid_d;
    logic [3:0]        seen_q, seen_d;
    logic              frame_q, frame_d;
    logic              changed_q, changed_d;
    logic              timeout_q, timeout_d;
    logic              sel_ok;
    logic [1:0]        idx;
    logic              commit;
    logic [7:0]        dec;

    function automatic logic [7:0] decode(input logic [7:0] s);
        case (s)
            8'hC0: decode = 8'h30;  8'hF9: decode = 8'h31;
            8'hA4: decode = 8'h32;  8'hB0: decode = 8'h33;
            8'h99: decode = 8'h34;  8'h92: decode = 8'h35;
            8'h82: decode = 8'h36;  8'hF8: decode = 8'h37;
            8'h80: decode = 8'h38;  8'h98: decode = 8'h39;
            8'h88: decode = 8'h41;  8'h83: decode = 8'h42;
            8'hC6: decode = 8'h43;  8'hA1: decode = 8'h44;
            8'h86: decode = 8'h45;  8'h8E: decode = 8'h46;
            8'h89: decode = 8'h48;  8'h8B: decode = 8'h68;
            8'hCF: decode = 8'h49;  8'hF1: decode = 8'h4A;
            8'hC7: decode = 8'h4C;  8'hC8: decode = 8'h4E;
            8'h8C: decode = 8'h50;  8'h40: decode = 8'h51;
            8'h8F: decode = 8'h54;  8'hC1: decode = 8'h55;
            8'h91: decode = 8'h59;  8'hBF: decode = 8'h2D;
            8'hFF: decode = 8'h20;  8'h7F: decode = 8'h2E;
            8'h79: decode = 8'h21;
            default: decode = 8'h3F;
        endcase
    endfunction

    always_comb begin
        sel_ok = 1'b1;
        idx    = 2'd0;
        case (sel_q)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: sel_ok = 1'b0;
        endcase
    end

    // Glitch filter: a pair must repeat RUN_LIM registered samples before it commits.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        commit  = 1'b0;
        if (!sel_ok) begin
            state_d = IDLE;
            run_d   = 8'd0;
        end else begin
            if (state_q == IDLE || {sel_q, seg_q} != prev_q) begin
                state_d = TRACK;
                run_d   = 8'd1;
            end else if (state_q == TRACK) begin
                run_d = run_q + 8'd1;
            end
            if (state_d == TRACK && run_d == RUN_LIM) begin
                commit  = 1'b1;
                state_d = HELD;
            end
        end
    end

    always_comb begin
        dec       = decode(seg_q);
        char_d    = char_q;
        valid_d   = valid_q;
        frame_d   = (seen_q == 4'hF);
        seen_d    = (seen_q == 4'hF) ? 4'h0 : seen_q;
        changed_d = 1'b0;
        tcnt_d    = tcnt_q;
        timeout_d = timeout_q;
        if (commit) begin
            changed_d      = (dec != char_q[idx]);
            char_d[idx]    = dec;
            valid_d[idx]   = 1'b1;
            seen_d[idx]    = 1'b1;
            tcnt_d         = '0;
            timeout_d      = 1'b0;
        end else if (tcnt_q != T_LIM) begin
            tcnt_d = tcnt_q + TW'(1);
            // Loss of scan invalidates everything but keeps the last chars visible.
            if (tcnt_d == T_LIM) begin
                timeout_d = 1'b1;
                valid_d   = 4'h0;
                seen_d    = 4'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            seg_q     <= 8'h00;
            sel_q     <= 4'h0;
            prev_q    <= 12'h000;
            run_q     <= 8'd0;
            tcnt_q    <= '0;
            char_q    <= {4{8'h20}};
            valid_q   <= 4'h0;
            seen_q    <= 4'h0;
            frame_q   <= 1'b0;
            changed_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            seg_q     <= bus.segments;
            sel_q     <= bus.digit_select;
            prev_q    <= {sel_q, seg_q};
            run_q     <= run_d;
            tcnt_q    <= tcnt_d;
            char_q    <= char_d;
            valid_q   <= valid_d;
            seen_q    <= seen_d;
            frame_q   <= frame_d;
            changed_q <= changed_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.char0      = char_q[0];
    assign bus.char1      = char_q[1];
    assign bus.char2      = char_q[2];
    assign bus.char3      = char_q[3];
    assign bus.char_valid = valid_q;
    assign bus.frame_done = frame_q;
    assign bus.changed    = changed_q;
    assign bus.timeout    = timeout_q;
endmodule
